// File: rtl/seq_bcd_display_pkg.sv
// Shared types and elaboration-time helpers for the sequential BCD display block.
`timescale 1ns/1ps
package seq_bcd_display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [6:0] SegBlank = 7'b1111111;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Decimal digits needed to hold the largest value of a given bit width.
  function automatic int unsigned dec_digits(input int unsigned width);
    logic [63:0] m;
    int unsigned n;
    m = (64'd1 << width) - 64'd1;
    n = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/seq_bcd_display_seven_segment.sv
// Active-low seven-segment decoder {g..a}; non-decimal codes decode as blank.
`timescale 1ns/1ps
module seq_bcd_display_seven_segment
  import seq_bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegBlank;
    case (digit_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SegBlank;
    endcase
  end

endmodule

// File: rtl/seq_bcd_display.sv
// Iterative double-dabble binary-to-BCD converter driving registered seven-segment digits,
// with start/busy/done handshake, leading-zero blanking and overflow saturation.
`timescale 1ns/1ps
module seq_bcd_display
  import seq_bcd_display_pkg::*;
#(
  parameter int unsigned IN_WIDTH      = 16,
  parameter int unsigned NUM_DIGITS    = 5,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     val,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [7*NUM_DIGITS-1:0] seg7
);

  localparam int unsigned InDigits  = dec_digits(IN_WIDTH);
  localparam int unsigned ScrDigits = (InDigits > NUM_DIGITS) ? InDigits : NUM_DIGITS;
  localparam int unsigned ScrW      = 4 * ScrDigits;
  localparam int unsigned BcdW      = 4 * NUM_DIGITS;
  localparam int unsigned SegW      = 7 * NUM_DIGITS;
  localparam int unsigned CntW      = $clog2(IN_WIDTH + 1);
  localparam logic [63:0] OvfLimit  = pow10(NUM_DIGITS);

  function automatic logic [SegW-1:0] reset_seg();
    logic [SegW-1:0] s;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      s[7*k +: 7] = (k == 0 || BLANK_LEADING == 0) ? 7'b1000000 : SegBlank;
    end
    return s;
  endfunction

  state_e                   state_q;
  logic [ScrW-1:0]          scr_q;
  logic [IN_WIDTH-1:0]      bin_q;
  logic [CntW-1:0]          cnt_q;
  logic                     ovf_q;

  logic [ScrW-1:0]          scr_adj;
  logic [ScrW+IN_WIDTH-1:0] shifted;
  logic [BcdW-1:0]          bcd_next;
  logic [SegW-1:0]          seg_next;
  logic [NUM_DIGITS-1:0]    blank;

  always_comb begin
    scr_adj = scr_q;
    for (int unsigned i = 0; i < ScrDigits; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {scr_adj, bin_q} << 1;

  // Saturation replaces the decoder input; blanking walks down from the top digit.
  always_comb begin
    logic run;
    run      = 1'b1;
    blank    = '0;
    bcd_next = ovf_q ? {NUM_DIGITS{4'h9}} : scr_q[BcdW-1:0];
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      run      = run && (bcd_next[4*k +: 4] == 4'd0);
      blank[k] = run && (k != 0) && (BLANK_LEADING != 0);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    logic [6:0] dec_seg;

    seq_bcd_display_seven_segment u_dec (
      .digit_i (bcd_next[4*g +: 4]),
      .seg_o   (dec_seg)
    );

    assign seg_next[7*g +: 7] = blank[g] ? SegBlank : dec_seg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      scr_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      seg7     <= reset_seg();
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bin_q   <= val;
            scr_q   <= '0;
            cnt_q   <= CntW'(IN_WIDTH);
            ovf_q   <= (64'(val) >= OvfLimit);
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          scr_q <= shifted[ScrW+IN_WIDTH-1:IN_WIDTH];
          bin_q <= shifted[IN_WIDTH-1:0];
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd      <= bcd_next;
          seg7     <= seg_next;
          overflow <= ovf_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bcd_display.sv
// Directed bench: three parameterisations share one stimulus stream and a vector table.
`timescale 1ns/1ps
module tb_seq_bcd_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] val;

  logic        busy_a, done_a, ovf_a;
  logic [19:0] bcd_a;
  logic [34:0] seg_a;
  logic        busy_b, done_b, ovf_b;
  logic [19:0] bcd_b;
  logic [34:0] seg_b;
  logic        busy_c, done_c, ovf_c;
  logic [15:0] bcd_c;
  logic [27:0] seg_c;

  always #5 clk = ~clk;

  seq_bcd_display #(.IN_WIDTH(16), .NUM_DIGITS(5), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .val(val), .busy(busy_a), .done(done_a),
    .overflow(ovf_a), .bcd(bcd_a), .seg7(seg_a)
  );

  seq_bcd_display #(.IN_WIDTH(16), .NUM_DIGITS(5), .BLANK_LEADING(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .val(val), .busy(busy_b), .done(done_b),
    .overflow(ovf_b), .bcd(bcd_b), .seg7(seg_b)
  );

  seq_bcd_display #(.IN_WIDTH(16), .NUM_DIGITS(4), .BLANK_LEADING(1)) dut_c (
    .clk(clk), .rst(rst), .start(start), .val(val), .busy(busy_c), .done(done_c),
    .overflow(ovf_c), .bcd(bcd_c), .seg7(seg_c)
  );

  typedef struct {
    logic [15:0] v;
    logic [19:0] bcd5;
    logic [15:0] bcd4;
    logic        ovf4;
  } vec_t;

  vec_t vecs [9];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [63:0] exp_seg(input logic [31:0] b, input int nd, input bit blank);
    logic [63:0] r;
    logic        run;
    logic [3:0]  d;
    r   = '0;
    run = 1'b1;
    for (int k = nd - 1; k >= 0; k--) begin
      d   = b[4*k +: 4];
      run = run && (d == 4'd0);
      r[7*k +: 7] = (run && k > 0 && blank) ? 7'b1111111 : seg_of(d);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy"}, {63'd0, busy_a | busy_b | busy_c}, 64'd0);
    check({tag, " done"}, {63'd0, done_a | done_b | done_c}, 64'd0);
    check({tag, " ovf"},  {63'd0, ovf_a | ovf_b | ovf_c}, 64'd0);
    check({tag, " bcd_a"}, 64'(bcd_a), 64'd0);
    check({tag, " bcd_c"}, 64'(bcd_c), 64'd0);
    check({tag, " seg_a"}, 64'(seg_a), {29'd0, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'b1000000});
    check({tag, " seg_b"}, 64'(seg_b), {29'd0, {5{7'b1000000}}});
    check({tag, " seg_c"}, 64'(seg_c), {36'd0, 7'h7f, 7'h7f, 7'h7f, 7'b1000000});
  endtask

  // Pulse start for one cycle and sample 20 cycles; done lands on sample 17.
  task automatic run_conv(input logic [15:0] v, output int bc, output int dc);
    @(negedge clk);
    val   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy_a) bc++;
      if (done_a) dc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int bc, dc;
    logic [19:0] held_bcd;

    vecs[0] = '{16'd4321,  20'h04321, 16'h4321, 1'b0};
    vecs[1] = '{16'd0,     20'h00000, 16'h0000, 1'b0};
    vecs[2] = '{16'hFFFF,  20'h65535, 16'h9999, 1'b1};
    vecs[3] = '{16'd7,     20'h00007, 16'h0007, 1'b0};
    vecs[4] = '{16'd12345, 20'h12345, 16'h9999, 1'b1};
    vecs[5] = '{16'd9999,  20'h09999, 16'h9999, 1'b0};
    vecs[6] = '{16'd10000, 20'h10000, 16'h9999, 1'b1};
    vecs[7] = '{16'd1,     20'h00001, 16'h0001, 1'b0};
    vecs[8] = '{16'd100,   20'h00100, 16'h0100, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    val   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    // Hand-decoded display for 4321 with the top digit blanked.
    run_conv(16'd4321, bc, dc);
    check("4321 seg literal", 64'(seg_a),
          {29'd0, 7'b1111111, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001});

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].v, bc, dc);
      check($sformatf("v%0d busy cycles", i), 64'(bc), 64'd17);
      check($sformatf("v%0d done pulses", i), 64'(dc), 64'd1);
      check($sformatf("v%0d bcd_a", i), 64'(bcd_a), 64'(vecs[i].bcd5));
      check($sformatf("v%0d bcd_b", i), 64'(bcd_b), 64'(vecs[i].bcd5));
      check($sformatf("v%0d ovf_a", i), 64'(ovf_a), 64'd0);
      check($sformatf("v%0d seg_a", i), 64'(seg_a), exp_seg(32'(vecs[i].bcd5), 5, 1'b1));
      check($sformatf("v%0d seg_b", i), 64'(seg_b), exp_seg(32'(vecs[i].bcd5), 5, 1'b0));
      check($sformatf("v%0d bcd_c", i), 64'(bcd_c), 64'(vecs[i].bcd4));
      check($sformatf("v%0d ovf_c", i), 64'(ovf_c), 64'(vecs[i].ovf4));
      check($sformatf("v%0d seg_c", i), 64'(seg_c), exp_seg(32'(vecs[i].bcd4), 4, 1'b1));
    end

    // Start held high, val changed mid-conversion: result must be the captured 100.
    @(negedge clk);
    val   = 16'd100;
    start = 1'b1;
    @(negedge clk);
    dc       = 0;
    held_bcd = '1;
    for (int i = 0; i < 18; i++) begin
      if (i == 2) val = 16'd555;
      if (done_a) begin
        dc++;
        held_bcd = bcd_a;
      end
      @(negedge clk);
    end
    check("held done pulses", 64'(dc), 64'd1);
    check("held bcd", 64'(held_bcd), 64'h00100);
    check("held restart busy", 64'(busy_a), 64'd1);

    // Reset five cycles into the back-to-back conversion of 555.
    repeat (4) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midrst");
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done_a || done_b || done_c) dc++;
      @(negedge clk);
    end
    check("midrst no done", 64'(dc), 64'd0);
    check("midrst bcd hold", 64'(bcd_a), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
